// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter sharing one data-memory port between the
//               core LSU (A) and the loader/debug port (B).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int MEM_DEPTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic                         a_we,
  input  logic [31:0]                  a_addr,
  input  logic [31:0]                  a_wdata,
  input  logic [3:0]                   a_wmask,
  output logic                         a_rvalid,
  output logic [31:0]                  a_rdata,
  output logic                         a_err,

  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic                         b_we,
  input  logic [31:0]                  b_addr,
  input  logic [31:0]                  b_wdata,
  input  logic [3:0]                   b_wmask,
  output logic                         b_rvalid,
  output logic [31:0]                  b_rdata,
  output logic                         b_err,

  output logic                         mem_en,
  output logic [3:0]                   mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  localparam logic C_GNT_A = 1'b0;
  localparam logic C_GNT_B = 1'b1;

  logic [0:0] r_state;
  logic       r_last_grant;
  logic       r_owner;
  logic       r_oor;

  logic        w_idle;
  logic        w_rd_wait;
  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_gnt;
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [3:0]  w_sel_wmask;
  logic        w_oor;
  logic        w_a_rsp;
  logic        w_b_rsp;
  logic        w_unused;

  // Gating with rst_n keeps every output at zero while reset is held.
  assign w_idle    = (r_state == S_IDLE) & rst_n;
  assign w_rd_wait = (r_state == S_RD_WAIT) & rst_n;

  assign w_gnt_a = w_idle & a_valid & (~b_valid | (r_last_grant == C_GNT_B));
  assign w_gnt_b = w_idle & b_valid & (~a_valid | (r_last_grant == C_GNT_A));
  assign w_gnt   = w_gnt_a | w_gnt_b;

  assign w_sel_we    = w_gnt_b ? b_we    : a_we;
  assign w_sel_addr  = w_gnt_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_gnt_b ? b_wdata : a_wdata;
  assign w_sel_wmask = w_gnt_b ? b_wmask : a_wmask;

  assign w_oor    = |w_sel_addr[31:AW+2];
  assign w_unused = ^w_sel_addr[1:0];

  assign a_ready = w_gnt_a;
  assign b_ready = w_gnt_b;

  // Out-of-range accesses are accepted but never reach the memory.
  assign mem_en    = w_gnt & ~w_oor;
  assign mem_we    = (w_gnt & w_sel_we & ~w_oor) ? w_sel_wmask : 4'b0000;
  assign mem_addr  = w_gnt ? w_sel_addr[AW+1:2] : '0;
  assign mem_wdata = w_gnt ? w_sel_wdata : 32'd0;

  assign w_a_rsp = w_rd_wait & (r_owner == C_GNT_A);
  assign w_b_rsp = w_rd_wait & (r_owner == C_GNT_B);

  assign a_rvalid = w_a_rsp;
  assign b_rvalid = w_b_rsp;
  assign a_rdata  = (w_a_rsp & ~r_oor) ? mem_rdata : 32'd0;
  assign b_rdata  = (w_b_rsp & ~r_oor) ? mem_rdata : 32'd0;

  assign a_err = (w_gnt_a & a_we & w_oor) | (w_a_rsp & r_oor);
  assign b_err = (w_gnt_b & b_we & w_oor) | (w_b_rsp & r_oor);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= C_GNT_B;
      r_owner      <= C_GNT_A;
      r_oor        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_last_grant <= w_gnt_b ? C_GNT_B : C_GNT_A;
            if (!w_sel_we) begin
              r_state <= S_RD_WAIT;
              r_owner <= w_gnt_b ? C_GNT_B : C_GNT_A;
              r_oor   <= w_oor;
            end
          end
        end
        S_RD_WAIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
